// File: rtl/gp_engine_pkg.sv
// Shared types for the GP-engine command executor: opcodes, FSM states and
// header field positions.
package gp_engine_pkg;

    typedef enum logic [1:0] {
        OP_END   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_WAIT  = 2'b11
    } opcode_t;

    typedef enum logic [3:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        OPD_REQ,
        OPD_WAIT,
        EXEC,
        RD_WAIT,
        DELAY,
        FINISH
    } state_t;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 30;
    localparam int ADDR_MSB = 29;

endpackage

// File: rtl/cmd_exec_fsm_if.sv
// Single-beat bus-master request channel driven by the command executor.
interface cmd_exec_fsm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mst_o_valid;
    logic [ADDR_WIDTH-1:0] mst_o_addr;
    logic [DATA_WIDTH-1:0] mst_o_wr_data;
    logic                  mst_o_rd0_wr1;
    logic                  mst_i_ready;
    logic                  mst_i_rd_valid;
    logic [DATA_WIDTH-1:0] mst_i_rd_data;

    modport master (
        output mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1,
        input  mst_i_ready, mst_i_rd_valid, mst_i_rd_data
    );

    modport slave (
        input  mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1,
        output mst_i_ready, mst_i_rd_valid, mst_i_rd_data
    );
endinterface

// File: rtl/cmd_exec_fsm_delay_cnt.sv
// Loadable down-counter used by the WAIT command; holds at zero.
module cmd_delay_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cmd_exec_fsm.sv
// Command-buffer execution engine: fetches two-word commands and runs them as
// single-beat master transactions (WRITE/READ), timed pauses (WAIT) or END.
module cmd_exec_fsm
    import gp_engine_pkg::*;
#(
    parameter int CMD_WIDTH      = 32,
    parameter int CMD_DEPTH      = 256,
    parameter int BUF_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BUF_ADDR_WIDTH-1:0] start_ptr,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATA_WIDTH-1:0]     last_rd_data,
    output logic                      cmd_rd_en,
    output logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic                      cmd_rd_valid,
    input  logic [CMD_WIDTH-1:0]      cmd_out,
    cmd_exec_fsm_if.master            mst
);
    state_t                    state;
    opcode_t                   hdr_op;
    logic [ADDR_MSB:0]         hdr_waddr;
    logic [BUF_ADDR_WIDTH-1:0] ptr;
    logic [BUF_ADDR_WIDTH-1:0] ptr_next;
    logic [BUF_ADDR_WIDTH-1:0] ptr_opd;
    logic                      ptr_last;
    logic                      step_done;
    logic                      cnt_load;
    logic                      cnt_en;
    logic                      cnt_zero;
    logic [31:0]               delay_val;
    logic [31:0]               cnt_load_val;
    logic [ADDR_WIDTH-1:0]     byte_addr;

    // Counter is loaded with operand-1 so that it reads zero on the last
    // DELAY cycle: N cycles for N >= 1, one cycle for N = 0.
    always_comb begin
        ptr_next     = ptr + BUF_ADDR_WIDTH'(2);
        ptr_opd      = ptr + BUF_ADDR_WIDTH'(1);
        ptr_last     = (ptr == BUF_ADDR_WIDTH'(CMD_DEPTH - 2));
        byte_addr    = ADDR_WIDTH'({hdr_waddr, 2'b00});
        delay_val    = 32'(cmd_out);
        cnt_load_val = (delay_val == '0) ? '0 : delay_val - 32'd1;
        cnt_load     = (state == OPD_WAIT) && cmd_rd_valid && (hdr_op == OP_WAIT);
        cnt_en       = (state == DELAY);
        step_done    = ((state == EXEC) && mst.mst_i_ready && (hdr_op == OP_WRITE))
                    || ((state == RD_WAIT) && mst.mst_i_rd_valid)
                    || ((state == DELAY) && cnt_zero);
    end

    cmd_delay_cnt #(.WIDTH(32)) u_delay_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            hdr_op            <= OP_END;
            hdr_waddr         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            last_rd_data      <= '0;
            cmd_rd_en         <= 1'b0;
            cmd_addr          <= '0;
            mst.mst_o_valid   <= 1'b0;
            mst.mst_o_addr    <= '0;
            mst.mst_o_wr_data <= '0;
            mst.mst_o_rd0_wr1 <= 1'b0;
        end else begin
            done      <= 1'b0;
            cmd_rd_en <= 1'b0;
            if (abort && (state != IDLE) && (state != FINISH)) begin
                mst.mst_o_valid <= 1'b0;
                busy            <= 1'b0;
                done            <= 1'b0 | 1'b1;
                state           <= FINISH;
            end else if (step_done) begin
                mst.mst_o_valid <= 1'b0;
                if (state == RD_WAIT) begin
                    last_rd_data <= mst.mst_i_rd_data;
                end
                if (ptr_last) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    ptr       <= ptr_next;
                    cmd_addr  <= ADDR_WIDTH'(ptr_next);
                    cmd_rd_en <= 1'b1;
                    state     <= HDR_REQ;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            ptr       <= start_ptr & ~BUF_ADDR_WIDTH'(1);
                            cmd_addr  <= ADDR_WIDTH'(start_ptr & ~BUF_ADDR_WIDTH'(1));
                            cmd_rd_en <= 1'b1;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            state     <= HDR_REQ;
                        end
                    end
                    HDR_REQ: state <= HDR_WAIT;
                    HDR_WAIT: begin
                        if (!cmd_rd_valid) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            hdr_op    <= opcode_t'(cmd_out[OPC_MSB:OPC_LSB]);
                            hdr_waddr <= cmd_out[ADDR_MSB:0];
                            if (opcode_t'(cmd_out[OPC_MSB:OPC_LSB]) == OP_END) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                cmd_rd_en <= 1'b1;
                                cmd_addr  <= ADDR_WIDTH'(ptr_opd);
                                state     <= OPD_REQ;
                            end
                        end
                    end
                    OPD_REQ: state <= OPD_WAIT;
                    OPD_WAIT: begin
                        if (!cmd_rd_valid) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else if (hdr_op == OP_WAIT) begin
                            state <= DELAY;
                        end else begin
                            mst.mst_o_valid   <= 1'b1;
                            mst.mst_o_addr    <= byte_addr;
                            mst.mst_o_wr_data <= (hdr_op == OP_WRITE) ? DATA_WIDTH'(cmd_out) : '0;
                            mst.mst_o_rd0_wr1 <= (hdr_op == OP_WRITE);
                            state             <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (mst.mst_i_ready) begin
                            mst.mst_o_valid <= 1'b0;
                            state           <= RD_WAIT;
                        end
                    end
                    RD_WAIT: state <= RD_WAIT;
                    DELAY:   state <= DELAY;
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_exec_fsm.sv
// Directed bench for cmd_exec_fsm with a one-cycle-latency buffer model and a
// programmable-delay bus slave.
module tb_cmd_exec_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_ptr = '0;
    logic        abort = 1'b0;
    logic        busy, done, err;
    logic [31:0] last_rd_data;
    logic        cmd_rd_en;
    logic [31:0] cmd_addr;
    logic        cmd_rd_valid = 1'b0;
    logic [31:0] cmd_out = '0;

    cmd_exec_fsm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cmd_exec_fsm #(
        .CMD_WIDTH(32), .CMD_DEPTH(256), .BUF_ADDR_WIDTH(8),
        .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_ptr(start_ptr), .abort(abort),
        .busy(busy), .done(done), .err(err), .last_rd_data(last_rd_data),
        .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr), .cmd_rd_valid(cmd_rd_valid),
        .cmd_out(cmd_out), .mst(bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [256];
    logic        drop_valid = 1'b0;
    int          rd_delay = 3;
    logic [31:0] rd_resp = '0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;

    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] max_addr = '0;
    logic [31:0] rd_addr_q [$];
    int          rd_cyc_q  [$];
    logic [31:0] acc_addr_q [$];
    logic [31:0] acc_data_q [$];
    logic        acc_wr_q   [$];
    int          acc_cyc_q  [$];

    // Buffer: data valid exactly one cycle after the read request.
    always @(posedge clk) begin
        cmd_rd_valid <= cmd_rd_en && !drop_valid;
        cmd_out      <= mem[cmd_addr[7:0]];
    end

    always @(posedge clk) begin
        bus.mst_i_rd_valid <= 1'b0;
        if (rd_pend) begin
            if (rd_cnt <= 1) begin
                bus.mst_i_rd_valid <= 1'b1;
                bus.mst_i_rd_data  <= rd_resp;
                rd_pend = 1'b0;
            end else begin
                rd_cnt = rd_cnt - 1;
            end
        end else if (bus.mst_o_valid && bus.mst_i_ready && !bus.mst_o_rd0_wr1) begin
            rd_pend = 1'b1;
            rd_cnt  = rd_delay;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cmd_rd_en) begin
            rd_addr_q.push_back(cmd_addr);
            rd_cyc_q.push_back(cyc);
            if (cmd_addr > max_addr) max_addr = cmd_addr;
        end
        if (bus.mst_o_valid && bus.mst_i_ready) begin
            acc_addr_q.push_back(bus.mst_o_addr);
            acc_data_q.push_back(bus.mst_o_wr_data);
            acc_wr_q.push_back(bus.mst_o_rd0_wr1);
            acc_cyc_q.push_back(cyc);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic clear_mon();
        rd_addr_q.delete(); rd_cyc_q.delete();
        acc_addr_q.delete(); acc_data_q.delete(); acc_wr_q.delete(); acc_cyc_q.delete();
        done_cnt = 0;
        max_addr = '0;
    endtask

    task automatic start_run(input logic [7:0] p);
        @(negedge clk);
        start_ptr = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.mst_o_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mst_i_ready = 1'b1;
        clear_mem();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err, cmd_rd_en, bus.mst_o_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, done, err, cmd_rd_en, bus.mst_o_valid});
        else passed++;
        total++;
        if (cmd_addr !== 32'h0 || last_rd_data !== 32'h0 || bus.mst_o_addr !== 32'h0)
            $display("FAIL reset_data: got addr=%h rd=%h maddr=%h want 0", cmd_addr, last_rd_data, bus.mst_o_addr);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        bit seen;
        clear_mem();
        mem[0] = 32'h4000_0010; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'h0000_0000;
        clear_mon();
        start_run(8'd0);
        total++;
        if (busy !== 1'b1 || cmd_rd_en !== 1'b1 || cmd_addr !== 32'd0)
            $display("FAIL write_first_fetch: got busy=%b rd_en=%b addr=%0d want 1 1 0", busy, cmd_rd_en, cmd_addr);
        else passed++;
        wait_done(50, seen);
        total++;
        if (!seen || err !== 1'b0 || busy !== 1'b0)
            $display("FAIL write_done: got seen=%b err=%b busy=%b want 1 0 0", seen, err, busy);
        else passed++;
        total++;
        if (acc_addr_q.size() != 1 || acc_addr_q[0] !== 32'h40 || acc_data_q[0] !== 32'hDEAD_BEEF || acc_wr_q[0] !== 1'b1)
            $display("FAIL write_beat: got n=%0d addr=%h data=%h wr=%b want 1 00000040 deadbeef 1",
                     acc_addr_q.size(), acc_addr_q[0], acc_data_q[0], acc_wr_q[0]);
        else passed++;
        total++;
        if (acc_cyc_q[0] - rd_cyc_q[0] != 4)
            $display("FAIL write_latency: got %0d want 4", acc_cyc_q[0] - rd_cyc_q[0]);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || done_cnt != 1)
            $display("FAIL write_done_pulse: got done=%b count=%0d want 0 1", done, done_cnt);
        else passed++;
    endtask

    task automatic test_read();
        bit seen;
        clear_mem();
        mem[0] = 32'h8000_0020; mem[1] = 32'h0;
        rd_delay = 3;
        rd_resp = 32'h1234_5678;
        clear_mon();
        start_run(8'd0);
        wait_done(60, seen);
        total++;
        if (!seen || err !== 1'b0)
            $display("FAIL read_done: got seen=%b err=%b want 1 0", seen, err);
        else passed++;
        total++;
        if (acc_addr_q.size() != 1 || acc_addr_q[0] !== 32'h80 || acc_wr_q[0] !== 1'b0)
            $display("FAIL read_beat: got n=%0d addr=%h wr=%b want 1 00000080 0",
                     acc_addr_q.size(), acc_addr_q[0], acc_wr_q[0]);
        else passed++;
        total++;
        if (last_rd_data !== 32'h1234_5678)
            $display("FAIL read_data: got %h want 12345678", last_rd_data);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_wait(input logic [31:0] n, input int gap);
        bit seen;
        clear_mem();
        mem[0] = 32'h4000_0010; mem[1] = 32'h1111_1111;
        mem[2] = 32'hC000_0000; mem[3] = n;
        mem[4] = 32'h4000_0020; mem[5] = 32'h2222_2222;
        mem[6] = 32'h0;
        clear_mon();
        start_run(8'd0);
        wait_done(100, seen);
        total++;
        if (!seen || acc_addr_q.size() != 2 || acc_addr_q[1] !== 32'h80 || acc_data_q[1] !== 32'h2222_2222)
            $display("FAIL wait_beats: got seen=%b n=%0d addr=%h data=%h want 1 2 00000080 22222222",
                     seen, acc_addr_q.size(), acc_addr_q[1], acc_data_q[1]);
        else passed++;
        total++;
        if (rd_addr_q[3] !== 32'd3 || rd_addr_q[4] !== 32'd4 || rd_cyc_q[4] - rd_cyc_q[3] != gap)
            $display("FAIL wait_gap_%0d: got addrs %0d,%0d gap %0d want 3,4 gap %0d",
                     n, rd_addr_q[3], rd_addr_q[4], rd_cyc_q[4] - rd_cyc_q[3], gap);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_ready_hold();
        bit seen;
        clear_mem();
        mem[0] = 32'h4000_0030; mem[1] = 32'hCAFE_F00D; mem[2] = 32'h0;
        clear_mon();
        bus.mst_i_ready = 1'b0;
        start_run(8'd0);
        wait_valid(20, seen);
        total++;
        if (!seen) $display("FAIL hold_valid_rise: got 0 want 1");
        else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.mst_o_valid !== 1'b1 || bus.mst_o_addr !== 32'hC0 ||
                bus.mst_o_wr_data !== 32'hCAFE_F00D || bus.mst_o_rd0_wr1 !== 1'b1)
                $display("FAIL hold_stable_%0d: got v=%b a=%h d=%h w=%b want 1 000000c0 cafef00d 1",
                         k, bus.mst_o_valid, bus.mst_o_addr, bus.mst_o_wr_data, bus.mst_o_rd0_wr1);
            else passed++;
            @(negedge clk);
        end
        bus.mst_i_ready = 1'b1;
        wait_done(20, seen);
        total++;
        if (!seen || acc_addr_q.size() != 1)
            $display("FAIL hold_single_accept: got seen=%b n=%0d want 1 1", seen, acc_addr_q.size());
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit seen;
        clear_mem();
        for (int i = 0; i < 128; i++) begin
            mem[2*i]   = 32'h4000_0000 | 32'(i);
            mem[2*i+1] = 32'(i);
        end
        clear_mon();
        start_run(8'd0);
        wait_done(1000, seen);
        total++;
        if (!seen || err !== 1'b1)
            $display("FAIL wrap_err: got seen=%b err=%b want 1 1", seen, err);
        else passed++;
        total++;
        if (acc_addr_q.size() != 128 || acc_addr_q[127] !== 32'h1FC || acc_data_q[127] !== 32'd127)
            $display("FAIL wrap_count: got n=%0d last=%h want 128 000001fc", acc_addr_q.size(), acc_addr_q[127]);
        else passed++;
        total++;
        if (max_addr !== 32'd255)
            $display("FAIL wrap_max_addr: got %0d want 255", max_addr);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_missing_valid();
        bit seen;
        clear_mem();
        mem[0] = 32'h4000_0010; mem[1] = 32'h1;
        clear_mon();
        drop_valid = 1'b1;
        start_run(8'd0);
        wait_done(10, seen);
        total++;
        if (!seen || err !== 1'b1 || acc_addr_q.size() != 0)
            $display("FAIL missing_valid: got seen=%b err=%b n=%0d want 1 1 0", seen, err, acc_addr_q.size());
        else passed++;
        drop_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_odd_ptr();
        bit seen;
        clear_mem();
        mem[4] = 32'h4000_0044; mem[5] = 32'hA5A5_A5A5; mem[6] = 32'h0;
        clear_mon();
        start_run(8'd5);
        total++;
        if (err !== 1'b0 || cmd_addr !== 32'd4)
            $display("FAIL odd_ptr_start: got err=%b addr=%0d want 0 4", err, cmd_addr);
        else passed++;
        wait_done(40, seen);
        total++;
        if (!seen || acc_addr_q.size() != 1 || acc_addr_q[0] !== 32'h110 || acc_data_q[0] !== 32'hA5A5_A5A5)
            $display("FAIL odd_ptr_beat: got seen=%b n=%0d addr=%h want 1 1 00000110", seen, acc_addr_q.size(), acc_addr_q[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_start();
        bit seen;
        clear_mem();
        mem[0] = 32'hC000_0000; mem[1] = 32'd10;
        mem[2] = 32'h4000_0050; mem[3] = 32'h5;
        mem[4] = 32'h0;
        mem[100] = 32'h4000_0099; mem[101] = 32'h1; mem[102] = 32'h0;
        clear_mon();
        start_run(8'd0);
        repeat (3) @(negedge clk);
        start_run(8'd100);
        wait_done(80, seen);
        total++;
        if (!seen || acc_addr_q.size() != 1 || acc_addr_q[0] !== 32'h140 || max_addr !== 32'd4)
            $display("FAIL busy_start_ignored: got seen=%b n=%0d addr=%h max=%0d want 1 1 00000140 4",
                     seen, acc_addr_q.size(), acc_addr_q[0], max_addr);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit seen;
        clear_mem();
        mem[0] = 32'h4000_0060; mem[1] = 32'h77; mem[2] = 32'h0;
        clear_mon();
        bus.mst_i_ready = 1'b0;
        start_run(8'd0);
        wait_valid(20, seen);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (!seen || bus.mst_o_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL abort_exec: got seen=%b valid=%b done=%b busy=%b want 1 0 1 0",
                     seen, bus.mst_o_valid, done, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || err !== 1'b0 || acc_addr_q.size() != 0)
            $display("FAIL abort_after: got done=%b err=%b n=%0d want 0 0 0", done, err, acc_addr_q.size());
        else passed++;
        bus.mst_i_ready = 1'b1;
        start = 1'b1; abort = 1'b1; start_ptr = 8'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || cmd_rd_en !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_beats_start: got busy=%b rd_en=%b done=%b want 0 0 0", busy, cmd_rd_en, done);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_rst_delay();
        clear_mem();
        mem[0] = 32'hC000_0000; mem[1] = 32'd30;
        clear_mon();
        start_run(8'd0);
        repeat (8) @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, err, cmd_rd_en, bus.mst_o_valid} !== 5'b0 || cmd_addr !== 32'h0 || last_rd_data !== 32'h0)
            $display("FAIL rst_async: got flags=%b addr=%h rd=%h want 00000 0 0",
                     {busy, done, err, cmd_rd_en, bus.mst_o_valid}, cmd_addr, last_rd_data);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt != 0 || busy !== 1'b0)
            $display("FAIL rst_no_done: got count=%0d busy=%b want 0 0", done_cnt, busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait(32'd5, 7);
        test_wait(32'd0, 3);
        test_ready_hold();
        test_wrap();
        test_missing_valid();
        test_odd_ptr();
        test_back_to_back_start();
        test_abort();
        test_rst_delay();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
